// File: rtl/sram_arbiter.sv
// Two-port (CPU / debug) arbiter for a single asynchronous SRAM: one word per grant, registered strobes.
// Define SRAM_ARBITER_FIXED_PRIO_EN to let the CPU always win ties instead of round-robin.
module sram_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              Mem_DriveEn,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                grant_dbg_reg, grant_dbg_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   cpu_rdata_reg, cpu_rdata_next;
  logic [DATA_W-1:0]   dbg_rdata_reg, dbg_rdata_next;
  logic                cpu_ack_reg, cpu_ack_next;
  logic                dbg_ack_reg, dbg_ack_next;
  logic                oe_n_reg, oe_n_next;
  logic                we_n_reg, we_n_next;
  logic                drive_reg, drive_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   dout_reg, dout_next;
  logic                pick_dbg;
  logic                active_next;
`ifndef SRAM_ARBITER_FIXED_PRIO_EN
  logic                last_dbg_reg, last_dbg_next;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      grant_dbg_reg <= 1'b0;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      cpu_rdata_reg <= '0;
      dbg_rdata_reg <= '0;
      cpu_ack_reg   <= 1'b0;
      dbg_ack_reg   <= 1'b0;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      drive_reg     <= 1'b0;
      mem_addr_reg  <= '0;
      dout_reg      <= '0;
`ifndef SRAM_ARBITER_FIXED_PRIO_EN
      last_dbg_reg  <= 1'b1;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      grant_dbg_reg <= grant_dbg_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      cpu_rdata_reg <= cpu_rdata_next;
      dbg_rdata_reg <= dbg_rdata_next;
      cpu_ack_reg   <= cpu_ack_next;
      dbg_ack_reg   <= dbg_ack_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      drive_reg     <= drive_next;
      mem_addr_reg  <= mem_addr_next;
      dout_reg      <= dout_next;
`ifndef SRAM_ARBITER_FIXED_PRIO_EN
      last_dbg_reg  <= last_dbg_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    grant_dbg_next = grant_dbg_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    cpu_rdata_next = cpu_rdata_reg;
    dbg_rdata_next = dbg_rdata_reg;
    cpu_ack_next   = 1'b0;
    dbg_ack_next   = 1'b0;
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
    pick_dbg       = !cpu_req;
`else
    last_dbg_next  = last_dbg_reg;
    pick_dbg       = (cpu_req && dbg_req) ? !last_dbg_reg : dbg_req;
`endif

    case (state_reg)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant_dbg_next = pick_dbg;
          we_next        = pick_dbg ? dbg_we    : cpu_we;
          addr_next      = pick_dbg ? dbg_addr  : cpu_addr;
          wdata_next     = pick_dbg ? dbg_wdata : cpu_wdata;
          cnt_next       = CNT_INIT;
          state_next     = ACCESS;
`ifndef SRAM_ARBITER_FIXED_PRIO_EN
          last_dbg_next  = pick_dbg;
`endif
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          // Ack is registered here so it is high exactly in the DONE cycle.
          state_next   = DONE;
          cpu_ack_next = !grant_dbg_reg;
          dbg_ack_next = grant_dbg_reg;
          if (!we_reg) begin
            if (grant_dbg_reg) dbg_rdata_next = Data_from_SRAM;
            else               cpu_rdata_next = Data_from_SRAM;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Strobes follow the next state so they are glitch-free registered outputs.
    active_next   = (state_next == ACCESS);
    oe_n_next     = !(active_next && !we_next);
    we_n_next     = !(active_next && we_next);
    drive_next    = active_next && we_next;
    mem_addr_next = active_next ? addr_next : mem_addr_reg;
    dout_next     = (active_next && we_next) ? wdata_next : dout_reg;
  end

  assign cpu_rdata    = cpu_rdata_reg;
  assign dbg_rdata    = dbg_rdata_reg;
  assign cpu_ack      = cpu_ack_reg;
  assign dbg_ack      = dbg_ack_reg;
  assign Mem_ADDR     = mem_addr_reg;
  assign Data_to_SRAM = dout_reg;
  assign Mem_DriveEn  = drive_reg;
  assign Mem_OE       = oe_n_reg;
  assign Mem_WE       = we_n_reg;
  assign Mem_CE       = 1'b0;
  assign Mem_UB       = 1'b0;
  assign Mem_LB       = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: transaction-level arbitration/memory model plus a small SRAM behavioural model.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int AC = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
  logic          cpu_ack, dbg_ack;
  logic [AW-1:0] Mem_ADDR;
  logic [DW-1:0] Data_to_SRAM, Data_from_SRAM;
  logic          Mem_DriveEn, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .Mem_ADDR(Mem_ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .Mem_DriveEn(Mem_DriveEn), .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  // SRAM device model (16 words, address aliased on the low bits).
  bit [DW-1:0] mem [16];
  assign Data_from_SRAM = (!Mem_OE) ? mem[Mem_ADDR[3:0]] : '0;
  always @(posedge Clk) if (!Mem_WE && Mem_DriveEn) mem[Mem_ADDR[3:0]] <= Data_to_SRAM;

  // Reference state: port index 0 = CPU, 1 = DBG.
  bit [DW-1:0] shadow [16];
  bit          pend [2];
  bit          pwe [2];
  bit [AW-1:0] paddr [2];
  bit [DW-1:0] pwd [2];
  bit [DW-1:0] exp_rd [2];
  int          last;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_ports();
    cpu_req = pend[0]; cpu_we = pwe[0]; cpu_addr = paddr[0]; cpu_wdata = pwd[0];
    dbg_req = pend[1]; dbg_we = pwe[1]; dbg_addr = paddr[1]; dbg_wdata = pwd[1];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_dbg_ack"}, 32'(dbg_ack), 32'd0);
    check({tag, "_oe"}, 32'(Mem_OE), 32'd1);
    check({tag, "_we"}, 32'(Mem_WE), 32'd1);
    check({tag, "_drv"}, 32'(Mem_DriveEn), 32'd0);
  endtask

  initial begin
    int g;
    bit gwe;
    bit [AW-1:0] gaddr;
    bit [DW-1:0] gwd;
    Reset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; pwe[p] = 0; paddr[p] = '0; pwd[p] = '0; exp_rd[p] = '0;
    end
    last = 1;
    drive_ports();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check_idle("rst");
    check("rst_addr", 32'(Mem_ADDR), 32'd0);
    check("rst_dout", 32'(Data_to_SRAM), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    check("rst_tie", {29'd0, Mem_CE, Mem_UB, Mem_LB}, 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 80; i++) begin
      // At a negedge inside an IDLE cycle: post new requests.
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p]  = 1;
          pwe[p]   = 1'($urandom_range(0, 1));
          paddr[p] = AW'($urandom);
          pwd[p]   = DW'($urandom);
        end
      end
      drive_ports();
      if (!pend[0] && !pend[1]) begin
        @(negedge Clk);
        check_idle("gap");
        continue;
      end
`ifdef SRAM_ARBITER_FIXED_PRIO_EN
      g = pend[0] ? 0 : 1;
`else
      g = (pend[0] && pend[1]) ? (1 - last) : (pend[1] ? 1 : 0);
`endif
      last = g;
      gwe = pwe[g]; gaddr = paddr[g]; gwd = pwd[g];

      for (int k = 1; k <= AC; k++) begin
        @(negedge Clk);
        check("acc_addr", 32'(Mem_ADDR), 32'(gaddr));
        check("acc_oe", 32'(Mem_OE), 32'(gwe));
        check("acc_we", 32'(Mem_WE), 32'(!gwe));
        check("acc_drv", 32'(Mem_DriveEn), 32'(gwe));
        if (gwe) check("acc_dout", 32'(Data_to_SRAM), 32'(gwd));
        check("acc_acks", {30'd0, dbg_ack, cpu_ack}, 32'd0);
        if (k == 1 && $urandom_range(0, 4) == 0) begin
          // Early drop with scrambled inputs: the granted access must be unaffected.
          pend[g] = 0; pwe[g] = 1'($urandom_range(0, 1));
          paddr[g] = AW'($urandom); pwd[g] = DW'($urandom);
          drive_ports();
        end
      end

      @(negedge Clk);
      if (gwe) shadow[gaddr[3:0]] = gwd;
      else     exp_rd[g] = shadow[gaddr[3:0]];
      check("done_cpu_ack", 32'(cpu_ack), 32'(g == 0));
      check("done_dbg_ack", 32'(dbg_ack), 32'(g == 1));
      check("done_cpu_rdata", 32'(cpu_rdata), 32'(exp_rd[0]));
      check("done_dbg_rdata", 32'(dbg_rdata), 32'(exp_rd[1]));
      check("done_strobes", {29'd0, Mem_OE, Mem_WE, Mem_DriveEn}, 32'b110);
      $display("txn %0d: port=%s we=%0d addr=%05h data=%04h", i, (g == 0) ? "cpu" : "dbg",
               gwe, gaddr, gwe ? gwd : exp_rd[g]);
      pend[g] = 0;
      drive_ports();
      @(negedge Clk);
      check_idle("post");
    end

    // Reset during the second ACCESS cycle of a CPU write: no ack, strobes drop.
    pend[0] = 1; pwe[0] = 1; paddr[0] = 20'h00005; pwd[0] = 16'hA5A5; pend[1] = 0;
    drive_ports();
    @(negedge Clk);
    check("rstw_we", 32'(Mem_WE), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    pend[0] = 0;
    drive_ports();
    check_idle("rstw");
    check("rstw_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rstw_dbg_rdata", 32'(dbg_rdata), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      check_idle("rstw_after");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single off-chip SRAM port between two requesters: the CPU (fetch, LDR, STR traffic) and a debug/host port (memory load, inspection).
- Each granted access is one word, read or write, and holds the SRAM for a fixed number of cycles.
- Sits between the requesters and the SRAM tristate/pin interface and owns all Mem_* control strobes.
- Round-robin arbitration by default.

Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- ACCESS_CYCLES, 2, cycles the SRAM strobes are held per access (legal range 1..15)

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request; held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered read data for the CPU
- cpu_ack  out  1  one-cycle completion pulse to the CPU
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack  same as cpu_* for the debug port
- Mem_ADDR  out  ADDR_W  SRAM address
- Data_to_SRAM  out  DATA_W  write data driven to the tristate buffer
- Data_from_SRAM  in  DATA_W  SRAM read data
- Mem_DriveEn  out  1  tristate enable; 1 only during write ACCESS cycles
- Mem_CE, Mem_UB, Mem_LB  out  1  tied 0 (active low, always enabled)
- Mem_OE, Mem_WE  out  1  active-low output enable and write enable

Behaviour:
- Reset state:
  - State = IDLE, last_grant = DBG, so the CPU wins the first tie.
  - cpu_ack = dbg_ack = 0; cpu_rdata = dbg_rdata = 0.
  - Mem_OE = Mem_WE = 1, Mem_DriveEn = 0, Mem_ADDR = 0, Data_to_SRAM = 0.
- Reset mid-access: the access is abandoned, no ack is issued, and strobes are deasserted on the next edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - If neither is high, stay in IDLE.
  - On grant, register grant, we, addr and wdata, update last_grant, and go to ACCESS with cnt = ACCESS_CYCLES-1.
- ACCESS:
  - Mem_ADDR = latched addr.
  - Read: Mem_OE = 0, Mem_WE = 1.
  - Write: Mem_WE = 0, Mem_OE = 1, Mem_DriveEn = 1, Data_to_SRAM = latched wdata.
  - Strobes are registered outputs, stable for all ACCESS_CYCLES cycles.
  - cnt decrements each cycle.
  - When cnt = 0 on a read, capture Data_from_SRAM into the granted port's rdata; the other port's rdata is unchanged.
  - When cnt = 0, go to DONE.
- DONE:
  - All strobes inactive.
  - Granted port's ack = 1 for exactly this cycle.
  - Next state is IDLE.
- Latency: req high in IDLE at cycle T → ack high at cycle T+1+ACCESS_CYCLES. Default is T+3.
- Throughput: one access per ACCESS_CYCLES+2 cycles.
- Handshake:
  - A requester keeps req, we, addr and wdata stable until ack.
  - It deasserts req in the cycle after ack, or holds it to request again.
  - A req dropped early is ignored once granted: the access completes and ack still pulses.
  - The address, command and data inputs are sampled only at grant.
- Reads and writes never overlap: Mem_OE and Mem_WE are never both 0 in any cycle.
- Wrap-around: addr is used as-is with no increment. cnt is sized for 15 and never underflows.
- Only one ack is ever high per cycle.

Optional Feature:
- Macro: SRAM_ARBITER_FIXED_PRIO_EN.
- Defined: the CPU always wins a tie in IDLE; last_grant is unused, so the debug port can be starved.
- Undefined: round-robin as above.

Test Plan:
- Reset, cpu_req = 1, cpu_we = 0, cpu_addr = 0x00010, SRAM returns 0x1234 → Mem_OE = 0 for 2 cycles, cpu_ack at T+3, cpu_rdata = 0x1234, dbg_rdata = 0.
- dbg_req write, addr 0x00020, wdata 0xBEEF → Mem_WE = 0 and Mem_DriveEn = 1 for 2 cycles, Data_to_SRAM = 0xBEEF, dbg_ack at T+3, Mem_OE stays 1 throughout.
- Both req held continuously after reset → grant order CPU, DBG, CPU, DBG with acks every 4 cycles; with SRAM_ARBITER_FIXED_PRIO_EN defined → only CPU acks.
- cpu_req pulsed for 1 cycle only → access still completes and cpu_ack pulses once; no second access starts.
- Reset asserted in the second ACCESS cycle of a write → next cycle Mem_WE = 1, Mem_DriveEn = 0, State IDLE, no ack ever.
- ACCESS_CYCLES = 4, cpu read → Mem_OE low for 4 cycles, ack at T+5.
